pp_accum_shift_reg: RTL and testbench



---
 rtl/mul_pkg.sv | 19 +
 rtl/pp_accum_shift_reg_pp_step_adder.sv | 27 ++
 rtl/pp_accum_shift_reg.sv | 109 ++++++++++
 tb/tb_pp_accum_shift_reg.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared parameters and types for the Booth multiplier datapath.
// Optional MAC initialisation is controlled by the PP_ACC_INIT_EN macro.
package mul_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SHIFT = 4;
    localparam int unsigned STEPS     = DEF_WIDTH / DEF_SHIFT;
    localparam int unsigned CNT_W     = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        PP_IDLE,
        PP_BUSY,
        PP_DONE
    } pp_state_e;

    typedef logic signed [DEF_WIDTH+DEF_SHIFT-1:0] pp_t;
    typedef logic signed [2*DEF_WIDTH-1:0]         prod_t;

endpackage

// File: rtl/pp_accum_shift_reg_pp_step_adder.sv
// Combinational accumulate step: add a sign-extended partial product into the
// high half of the running product, then arithmetic-shift right by SHIFT.
module pp_step_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHIFT = 4
) (
    input  logic [2*WIDTH+SHIFT:0]   p,
    input  logic [WIDTH+SHIFT-1:0]   pp,
    output logic [2*WIDTH+SHIFT:0]   p_next
);

    localparam int unsigned PW = 2*WIDTH + SHIFT + 1;
    localparam int unsigned HW = WIDTH + SHIFT + 1;

    logic signed [HW-1:0] hi;
    logic signed [HW-1:0] pp_ext;
    logic signed [HW-1:0] sum;
    logic signed [PW-1:0] cat;

    assign hi     = p[PW-1:WIDTH];
    assign pp_ext = HW'($signed(pp));
    assign sum    = hi + pp_ext;
    // {sum, LO} is exactly PW bits; one arithmetic shift retires SHIFT bits.
    assign cat    = {sum, p[WIDTH-1:0]};
    assign p_next = cat >>> SHIFT;

endmodule

// File: rtl/pp_accum_shift_reg.sv
// Booth partial-product accumulator / shift register with valid/ready ports.
// Define PP_ACC_INIT_EN to add acc_init for multiply-accumulate.
module pp_accum_shift_reg
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SHIFT = DEF_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     pp_valid,
    output logic                     pp_ready,
    input  logic [WIDTH+SHIFT-1:0]   pp_in,
`ifdef PP_ACC_INIT_EN
    input  logic [2*WIDTH-1:0]       acc_init,
`endif
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [2*WIDTH-1:0]       res_out,
    output logic                     busy
);

    localparam int unsigned PW      = 2*WIDTH + SHIFT + 1;
    localparam int unsigned N_STEPS = WIDTH / SHIFT;
    localparam int unsigned CW      = $clog2(N_STEPS + 1);

    pp_state_e       state;
    logic [PW-1:0]   p_q;
    logic [PW-1:0]   p_next;
    logic [PW-1:0]   p_init;
    logic [CW-1:0]   cnt;

    pp_step_adder #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_step (
        .p      (p_q),
        .pp     (pp_in),
        .p_next (p_next)
    );

`ifdef PP_ACC_INIT_EN
    // Pre-shift left by WIDTH so the STEPS right shifts bring it back into place.
    logic signed [3*WIDTH-1:0] init_aligned;
    assign init_aligned = {acc_init, WIDTH'(0)};
    assign p_init       = PW'(init_aligned);
`else
    assign p_init = '0;
`endif

    assign res_out = p_q[2*WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PP_IDLE;
            p_q       <= '0;
            cnt       <= '0;
            pp_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (abort) begin
            state     <= PP_IDLE;
            p_q       <= '0;
            cnt       <= '0;
            pp_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                PP_IDLE: begin
                    if (start) begin
                        state    <= PP_BUSY;
                        p_q      <= p_init;
                        cnt      <= '0;
                        pp_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                PP_BUSY: begin
                    if (pp_valid) begin
                        p_q <= p_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(N_STEPS - 1)) begin
                            state     <= PP_DONE;
                            pp_ready  <= 1'b0;
                            res_valid <= 1'b1;
                        end
                    end
                end
                PP_DONE: begin
                    if (res_ready) begin
                        state     <= PP_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= PP_IDLE;
                    pp_ready  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pp_accum_shift_reg.sv
// Directed and Booth-encoded random checks of pp_accum_shift_reg at WIDTH=8, SHIFT=4.
module tb_pp_accum_shift_reg;

    localparam int unsigned W = 8;
    localparam int unsigned S = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              pp_valid;
    logic              pp_ready;
    logic [W+S-1:0]    pp_in;
    logic              res_valid;
    logic              res_ready;
    logic [2*W-1:0]    res_out;
    logic              busy;
`ifdef PP_ACC_INIT_EN
    logic [2*W-1:0]    acc_init;
`endif

    int n_run  = 0;
    int n_fail = 0;

    pp_accum_shift_reg #(.WIDTH(W), .SHIFT(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .pp_valid  (pp_valid),
        .pp_ready  (pp_ready),
        .pp_in     (pp_in),
`ifdef PP_ACC_INIT_EN
        .acc_init  (acc_init),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_out   (res_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full product: start, two back-to-back PPs, result, handshake back to IDLE.
    task automatic run(input int a, input int b, input logic [15:0] exp, input string tag);
        res_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check({tag, "_ppready"}, 64'(pp_ready), 64'd1);
        pp_valid = 1'b1;
        pp_in = 12'(a); tick();
        pp_in = 12'(b); tick();
        pp_valid = 1'b0;
        check({tag, "_valid"}, 64'(res_valid), 64'd1);
        check({tag, "_res"}, 64'(res_out), 64'(exp));
        tick();
        check({tag, "_idle"}, {62'd0, busy, res_valid}, 64'd0);
    endtask

    function automatic int booth_digit(input logic [7:0] y, input int i);
        logic [8:0] ye;
        ye = {y, 1'b0};
        return -8 * int'(ye[4*i+4]) + 4 * int'(ye[4*i+3]) + 2 * int'(ye[4*i+2])
               + int'(ye[4*i+1]) + int'(ye[4*i]);
    endfunction

    initial begin
        logic [7:0]  rx;
        logic [7:0]  ry;
        logic [15:0] rexp;
        int          xi;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; pp_valid = 1'b0;
        pp_in = '0; res_ready = 1'b0;
`ifdef PP_ACC_INIT_EN
        acc_init = '0;
`endif
        #12;
        check("reset_outs", {45'd0, pp_ready, res_valid, busy, res_out}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("idle_ppready", 64'(pp_ready), 64'd0);

        // Stray pp_valid in IDLE is not accepted
        pp_valid = 1'b1; pp_in = 12'd9; tick(); pp_valid = 1'b0;
        check("idle_stray_pp", {62'd0, busy, pp_ready}, 64'd0);

        run(5, 3, 16'h0035, "basic");
        run(-8, 1, 16'h0008, "neg1");
        run(-1, -1, 16'hFFEF, "neg2");

        // Backpressure in DONE with stray start and pp_valid
        res_ready = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        pp_valid = 1'b1; pp_in = 12'd5; tick();
        pp_in = 12'd3; tick();
        start = 1'b1; pp_in = 12'd7;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(res_valid), 64'd1);
            check("bp_res", 64'(res_out), 64'h0035);
            check("bp_ppready", 64'(pp_ready), 64'd0);
            tick();
        end
        pp_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        check("bp_release", {62'd0, busy, res_valid}, 64'd0);
        start = 1'b0;
        tick();
        check("bp_no_restart", {62'd0, busy, pp_ready}, 64'd0);

        // Abort after first PP, together with pp_valid
        start = 1'b1; tick(); start = 1'b0;
        pp_valid = 1'b1; pp_in = 12'd7; tick();
        abort = 1'b1; tick(); abort = 1'b0; pp_valid = 1'b0;
        check("abort_state", {61'd0, busy, pp_ready, res_valid}, 64'd0);
        check("abort_res", 64'(res_out), 64'd0);
        tick();
        check("abort_stays", 64'(res_valid), 64'd0);
        run(2, 0, 16'h0002, "post_abort");

        // Asynchronous reset mid-BUSY
        start = 1'b1; tick(); start = 1'b0;
        pp_valid = 1'b1; pp_in = 12'd6; tick(); pp_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {45'd0, pp_ready, res_valid, busy, res_out}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_idle", {62'd0, busy, pp_ready}, 64'd0);

        // Accumulator initial value
`ifdef PP_ACC_INIT_EN
        acc_init = 16'h0100;
        run(5, 3, 16'h0135, "mac");
        acc_init = 16'h0000;
`else
        run(5, 3, 16'h0035, "mac_off");
`endif

        // Booth-encoded random products against a reference multiply
        for (int k = 0; k < 200; k++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            xi = int'($signed(rx));
            rexp = 16'(xi * int'($signed(ry)));
            run(booth_digit(ry, 0) * xi, booth_digit(ry, 1) * xi, rexp, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
